config_loader_seq: RTL

CONFIG_LOADER_SEQ -- requirements
Module: config_loader_seq

---
 rtl/config_loader_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/config_loader_seq.sv
`default_nettype none
// ============================================================================
// Module      : config_loader_seq
// Description : Sequencer for the configuration loader. It counts the loader
//               words arriving on wr_valid and steers each one to the state
//               table, the per-column ctrl/imm config tables, or the inbound
//               buffer. For each consumed word it raises exactly one write
//               strobe, together with that word's entry address.
//
// Ports       : clk, rst                  - clock, synchronous active-high reset
//               start_loader              - one-cycle request to begin a load
//               num_entry_config_table    - ctrl/imm entries per column (N)
//               num_entry_inbound         - inbound-buffer entries (M)
//               wr_valid, wr_data         - incoming loader word
//               state_wr_en               - state-table write strobe
//               cfg_ctrl_wr_en            - ctrl config-table write strobe
//               cfg_imm_wr_en             - imm config-table write strobe
//               cfg_col                   - column targeted by config writes
//               inb_wr_en                 - inbound-buffer write strobe
//               wr_add                    - entry address for the active strobe
//               busy, done, ready         - load status
//
// Revision    : 1.0 - initial release
// ============================================================================
module config_loader_seq #(
    parameter int PHIT_SIZE       = 512,
    parameter int NUM_COL         = 6,
    parameter int DWIDTH_RFADD    = 8,
    parameter int NUM_STATE_ENTRY = 2,
    localparam int COL_W          = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_loader,
    input  logic [DWIDTH_RFADD-1:0] num_entry_config_table,
    input  logic [DWIDTH_RFADD-1:0] num_entry_inbound,
    input  logic                    wr_valid,
    input  logic [PHIT_SIZE-1:0]    wr_data,
    output logic                    state_wr_en,
    output logic                    cfg_ctrl_wr_en,
    output logic                    cfg_imm_wr_en,
    output logic [COL_W-1:0]        cfg_col,
    output logic                    inb_wr_en,
    output logic [DWIDTH_RFADD-1:0] wr_add,
    output logic                    busy,
    output logic                    done,
    output logic                    ready
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_LD_STATE = 3'd1;
    localparam logic [2:0] c_ST_LD_CTRL  = 3'd2;
    localparam logic [2:0] c_ST_LD_IMM   = 3'd3;
    localparam logic [2:0] c_ST_LD_INB   = 3'd4;
    localparam logic [2:0] c_ST_LOADED   = 3'd5;

    localparam logic [DWIDTH_RFADD-1:0] c_STATE_LAST = DWIDTH_RFADD'(NUM_STATE_ENTRY - 1);
    localparam logic [COL_W-1:0]        c_COL_LAST   = COL_W'(NUM_COL - 1);
    localparam logic [DWIDTH_RFADD-1:0] c_ADD_ONE    = DWIDTH_RFADD'(1);
    localparam logic [COL_W-1:0]        c_COL_ONE    = COL_W'(1);

    logic [2:0]              r_state;
    logic [DWIDTH_RFADD-1:0] r_wr_add;
    logic [COL_W-1:0]        r_cfg_col;
    logic [DWIDTH_RFADD-1:0] r_num_cfg;
    logic [DWIDTH_RFADD-1:0] r_num_inb;
    logic                    r_done;

    logic [2:0]              w_state_nxt;
    logic [DWIDTH_RFADD-1:0] w_wr_add_nxt;
    logic [COL_W-1:0]        w_cfg_col_nxt;
    logic                    w_latch_counts;
    logic                    w_busy;
    logic [2:0]              w_after_cfg;
    logic [2:0]              w_after_state;
    logic                    w_unused_data;

    // The payload travels on a separate datapath; here it is only counted.
    assign w_unused_data = ^wr_data;

    // An empty phase is skipped by choosing the successor at the boundary.
    assign w_after_cfg   = (r_num_inb != '0) ? c_ST_LD_INB : c_ST_LOADED;
    assign w_after_state = (r_num_cfg != '0) ? c_ST_LD_CTRL : w_after_cfg;

    assign w_busy = (r_state == c_ST_LD_STATE) || (r_state == c_ST_LD_CTRL) ||
                    (r_state == c_ST_LD_IMM)   || (r_state == c_ST_LD_INB);

    always_comb begin
        w_state_nxt    = r_state;
        w_wr_add_nxt   = r_wr_add;
        w_cfg_col_nxt  = r_cfg_col;
        w_latch_counts = 1'b0;
        state_wr_en    = 1'b0;
        cfg_ctrl_wr_en = 1'b0;
        cfg_imm_wr_en  = 1'b0;
        inb_wr_en      = 1'b0;

        case (r_state)
            c_ST_IDLE, c_ST_LOADED: begin
                if (start_loader) begin
                    w_state_nxt    = c_ST_LD_STATE;
                    w_wr_add_nxt   = '0;
                    w_cfg_col_nxt  = '0;
                    w_latch_counts = 1'b1;
                end
            end
            c_ST_LD_STATE: begin
                state_wr_en = wr_valid;
                if (wr_valid) begin
                    if (r_wr_add == c_STATE_LAST) begin
                        w_wr_add_nxt  = '0;
                        w_cfg_col_nxt = '0;
                        w_state_nxt   = w_after_state;
                    end else begin
                        w_wr_add_nxt = r_wr_add + c_ADD_ONE;
                    end
                end
            end
            c_ST_LD_CTRL: begin
                cfg_ctrl_wr_en = wr_valid;
                if (wr_valid) begin
                    if (r_wr_add == r_num_cfg - c_ADD_ONE) begin
                        w_wr_add_nxt = '0;
                        w_state_nxt  = c_ST_LD_IMM;
                    end else begin
                        w_wr_add_nxt = r_wr_add + c_ADD_ONE;
                    end
                end
            end
            c_ST_LD_IMM: begin
                cfg_imm_wr_en = wr_valid;
                if (wr_valid) begin
                    if (r_wr_add == r_num_cfg - c_ADD_ONE) begin
                        w_wr_add_nxt = '0;
                        if (r_cfg_col != c_COL_LAST) begin
                            w_cfg_col_nxt = r_cfg_col + c_COL_ONE;
                            w_state_nxt   = c_ST_LD_CTRL;
                        end else begin
                            w_state_nxt = w_after_cfg;
                        end
                    end else begin
                        w_wr_add_nxt = r_wr_add + c_ADD_ONE;
                    end
                end
            end
            c_ST_LD_INB: begin
                inb_wr_en = wr_valid;
                if (wr_valid) begin
                    if (r_wr_add == r_num_inb - c_ADD_ONE) begin
                        w_wr_add_nxt = '0;
                        w_state_nxt  = c_ST_LOADED;
                    end else begin
                        w_wr_add_nxt = r_wr_add + c_ADD_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt   = c_ST_IDLE;
                w_wr_add_nxt  = '0;
                w_cfg_col_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_wr_add  <= '0;
            r_cfg_col <= '0;
            r_num_cfg <= '0;
            r_num_inb <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_add  <= w_wr_add_nxt;
            r_cfg_col <= w_cfg_col_nxt;
            // The only way into LOADED from a busy state is via the last word.
            r_done    <= w_busy && (w_state_nxt == c_ST_LOADED);
            if (w_latch_counts) begin
                r_num_cfg <= num_entry_config_table;
                r_num_inb <= num_entry_inbound;
            end
        end
    end

    assign busy    = w_busy;
    assign done    = r_done;
    assign ready   = (r_state == c_ST_LOADED);
    assign wr_add  = r_wr_add;
    assign cfg_col = r_cfg_col;

endmodule
`default_nettype wire
